// File: rtl/tty_ram_sched.sv
// tty_ram_sched: shares the text RAM port between renderer reads and a scroll/clear engine (optional TTY_ARB_FAIR_EN)
module tty_ram_sched #(
    parameter int          COLS      = 60,
    parameter int          ROWS      = 17,
    parameter int          ADDR_W    = 16,
    parameter int          BASE      = 0,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [7:0]        disp_rdata,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write,
    output logic [7:0]        ram_writedata,
    input  logic [7:0]        ram_readdata
);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'(BASE + COLS * (ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(BASE + COLS * ROWS - 1);

    if (longint'(BASE) + longint'(COLS) * ROWS >= (longint'(1) << ADDR_W)) begin : g_bad_range
        $error("tty_ram_sched: BASE+COLS*ROWS does not fit in ADDR_W");
    end

    typedef enum logic [2:0] {IDLE, SCR_RD, SCR_CAP, SCR_WR, CLR_WR, FIN} state_t;
    state_t st, nxt;
    logic [ADDR_W-1:0] dst, src;
    logic [7:0]        hold;
    logic              need, go;

    assign src        = dst + ADDR_W'(COLS);
    assign need       = st == SCR_RD || st == SCR_WR || st == CLR_WR;
    assign go         = need && !disp_gnt;
    assign disp_rdata = ram_readdata;

`ifdef TTY_ARB_FAIR_EN
    logic [3:0] wait_cnt;
    logic       force_slot;
    assign disp_gnt = disp_req && !force_slot;
    // after 16 consecutive grants that keep the engine waiting, hand it one slot
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wait_cnt   <= '0;
            force_slot <= 1'b0;
        end else if (!need || !disp_gnt) begin
            wait_cnt   <= '0;
            force_slot <= 1'b0;
        end else begin
            wait_cnt   <= wait_cnt + 4'd1;
            force_slot <= wait_cnt == 4'hf;
        end
`else
    assign disp_gnt = disp_req;
`endif

    // engine state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else        st <= nxt;

    // pointer and copy buffer; pointer advances only on a granted write
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dst  <= BASE_A;
            hold <= '0;
        end else begin
            if (st == IDLE) dst <= BASE_A;
            else if (go && (st == SCR_WR || st == CLR_WR)) dst <= dst + ADDR_W'(1);
            if (st == SCR_CAP) hold <= ram_readdata;
        end

    // read data follows a display grant by one cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) disp_rvalid <= 1'b0;
        else        disp_rvalid <= disp_gnt;

    // next-state logic; port accesses stall while the display holds the port
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = !cmd_valid ? IDLE : cmd_op == 2'b01 ? SCR_RD : cmd_op == 2'b10 ? CLR_WR : IDLE;
            SCR_RD:  nxt = go ? SCR_CAP : SCR_RD;
            SCR_CAP: nxt = SCR_WR;
            SCR_WR:  nxt = !go ? SCR_WR : dst == SCR_LAST ? CLR_WR : SCR_RD;
            CLR_WR:  nxt = go && dst == CLR_LAST ? FIN : CLR_WR;
            default: nxt = IDLE;
        endcase
    end

    // port mux and status outputs
    always_comb begin
        ram_address   = disp_gnt ? disp_addr : st == SCR_RD ? src : (st == SCR_WR || st == CLR_WR) ? dst : BASE_A;
        ram_write     = !disp_gnt && (st == SCR_WR || st == CLR_WR);
        ram_writedata = st == SCR_WR ? hold : FILL_CHAR;
        busy          = st != IDLE && st != FIN;
        done          = st == FIN;
        cmd_ready     = st == IDLE;
    end
endmodule
